// File: rtl/adc_pack_pkg.sv
// adc_pack_pkg: shared widths, trailer tag and FSM states for the ADC frame packer
package adc_pack_pkg;
   localparam int DATA_W = 32;
   localparam int CNT_W = 16;
   localparam logic [7:0] TRAILER_TAG = 8'hE0;
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PAYLOAD,
      S_TRAILER,
      S_CSUM,
      S_FLIP,
      S_WAIT
   } state_t;
endpackage

// File: rtl/pack_skid_buf.sv
// pack_skid_buf: 2-entry valid/ready output buffer exposing its occupancy for read gating
module pack_skid_buf
   import adc_pack_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              push_last_i,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [1:0]        count_o
);
   logic [DATA_W:0] mem_q [2];
   logic            wr_q;
   logic            rd_q;
   logic [1:0]      cnt_q;
   logic            pop;
   assign valid_o = cnt_q != 2'd0;
   assign pop = valid_o & ready_i;
   assign {last_o, data_o} = mem_q[rd_q];
   assign count_o = cnt_q;
   // Two-slot ring; the head is presented directly so it holds steady while stalled
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q <= 1'b0;
         rd_q <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push_i) mem_q[wr_q] <= {push_last_i, push_data_i};
         wr_q <= wr_q ^ push_i;
         rd_q <= rd_q ^ pop;
         cnt_q <= cnt_q + 2'(push_i) - 2'(pop);
      end
endmodule

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: drains ping-pong FIFO banks into header/payload/trailer frames on a valid/ready stream.
// Build option ADC_PACK_CHECKSUM_EN appends a payload-sum word that then carries m_last.
module adc_frame_packer
   import adc_pack_pkg::*;
#(
   parameter int unsigned BURST_LEN = 512,
   parameter logic [15:0] HDR_MAGIC = 16'hA55A,
   parameter int unsigned FLIP_WAIT = 64
) (
   input  logic              clk_100m,
   input  logic              rst,
   input  logic              full_ppfifo,
   input  logic              empty_ppfifo,
   input  logic              done_task,
   output logic              adc_out_rd,
   input  logic [DATA_W-1:0] data_out_adc,
   output logic              force_flip,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [CNT_W-1:0]  seq_num
);
   localparam logic [CNT_W:0] BL = BURST_LEN[CNT_W:0];
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FLIP_WAIT - 1);
   state_t            state_q;
   logic [2:0]        sync_q;
   logic [CNT_W-1:0]  seq_q;
   logic [CNT_W-1:0]  n_q;
   logic [CNT_W-1:0]  wait_q;
   logic              flush_q;
   logic              flush_pend_q;
   logic              rd_pend_q;
   logic              force_flip_q;
   logic [1:0]        sb_count;
   logic [2:0]        occ;
   logic              pop;
   logic              space;
   logic              done_edge;
   logic              hdr_push;
   logic              trl_push;
   logic              push;
   logic              push_last;
   logic [DATA_W-1:0] push_data;
`ifdef ADC_PACK_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;
   logic              csum_push;
`endif
   assign pop = m_valid & m_ready;
   assign done_edge = sync_q[1] & ~sync_q[2];
   assign force_flip = force_flip_q;
   assign seq_num = seq_q;
   // Read gating and buffer push selection; a read is only issued when its word is guaranteed a slot
   always_comb begin
      occ = {1'b0, sb_count} - {2'b0, pop} + {2'b0, rd_pend_q};
      space = sb_count != 2'd2 || pop;
      adc_out_rd = state_q == S_PAYLOAD && !empty_ppfifo && occ < 3'd2 &&
                   ({1'b0, n_q} + {{CNT_W{1'b0}}, rd_pend_q}) < BL;
      hdr_push = state_q == S_HDR && space;
      trl_push = state_q == S_TRAILER && space;
`ifdef ADC_PACK_CHECKSUM_EN
      csum_push = state_q == S_CSUM && space;
      push_last = csum_push;
      push = hdr_push | trl_push | csum_push | rd_pend_q;
      push_data = hdr_push ? {HDR_MAGIC, seq_q} :
                  trl_push ? {TRAILER_TAG, 7'd0, flush_q, n_q} :
                  csum_push ? csum_q : data_out_adc;
`else
      push_last = trl_push;
      push = hdr_push | trl_push | rd_pend_q;
      push_data = hdr_push ? {HDR_MAGIC, seq_q} :
                  trl_push ? {TRAILER_TAG, 7'd0, flush_q, n_q} : data_out_adc;
`endif
   end
   // Task-done synchroniser, frame sequencing, payload counting and flush handshake
   always_ff @(posedge clk_100m or posedge rst)
      if (rst) begin
         state_q <= S_IDLE;
         sync_q <= 3'd0;
         seq_q <= '0;
         n_q <= '0;
         wait_q <= '0;
         flush_q <= 1'b0;
         flush_pend_q <= 1'b0;
         rd_pend_q <= 1'b0;
         force_flip_q <= 1'b0;
`ifdef ADC_PACK_CHECKSUM_EN
         csum_q <= '0;
`endif
      end else begin
         sync_q <= {sync_q[1:0], done_task};
         rd_pend_q <= adc_out_rd;
         force_flip_q <= 1'b0;
         if (done_edge) flush_pend_q <= 1'b1;
         if (rd_pend_q) begin
            n_q <= n_q + 1'b1;
`ifdef ADC_PACK_CHECKSUM_EN
            csum_q <= csum_q + data_out_adc;
`endif
         end
         case (state_q)
            S_IDLE:
               if (full_ppfifo) begin
                  state_q <= S_HDR;
                  flush_q <= 1'b0;
               end else if (flush_pend_q) begin
                  state_q <= S_FLIP;
                  force_flip_q <= 1'b1;
               end
            S_FLIP: begin
               flush_pend_q <= done_edge;
               wait_q <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT:
               if (!empty_ppfifo) begin
                  state_q <= S_HDR;
                  flush_q <= 1'b1;
               end else if (wait_q == WAIT_LAST) state_q <= S_IDLE;
               else wait_q <= wait_q + 1'b1;
            S_HDR: begin
               n_q <= '0;
`ifdef ADC_PACK_CHECKSUM_EN
               csum_q <= '0;
`endif
               if (hdr_push) state_q <= S_PAYLOAD;
            end
            S_PAYLOAD:
               if (!rd_pend_q && (n_q == BL[CNT_W-1:0] || empty_ppfifo)) state_q <= S_TRAILER;
            S_TRAILER:
               if (trl_push) begin
`ifdef ADC_PACK_CHECKSUM_EN
                  state_q <= S_CSUM;
`else
                  state_q <= S_IDLE;
                  seq_q <= seq_q + 1'b1;
`endif
               end
`ifdef ADC_PACK_CHECKSUM_EN
            S_CSUM:
               if (csum_push) begin
                  state_q <= S_IDLE;
                  seq_q <= seq_q + 1'b1;
               end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   pack_skid_buf u_skid (
      .clk         (clk_100m),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_data),
      .push_last_i (push_last),
      .data_o      (m_data),
      .last_o      (m_last),
      .valid_o     (m_valid),
      .ready_i     (m_ready),
      .count_o     (sb_count)
   );
endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: directed/random frame checks of adc_frame_packer against a frame-list reference model
`timescale 1ns/1ps
module tb_adc_frame_packer;
   localparam int BL = 4;
   logic        clk_100m = 1'b0;
   logic        rst = 1'b1;
   logic        full_ppfifo = 1'b0;
   logic        empty_ppfifo = 1'b1;
   logic        done_task = 1'b0;
   logic        adc_out_rd;
   logic [31:0] data_out_adc = '0;
   logic        force_flip;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        m_last;
   logic [15:0] seq_num;

   adc_frame_packer #(.BURST_LEN(BL), .HDR_MAGIC(16'hA55A), .FLIP_WAIT(64)) dut (
      .clk_100m     (clk_100m),
      .rst          (rst),
      .full_ppfifo  (full_ppfifo),
      .empty_ppfifo (empty_ppfifo),
      .done_task    (done_task),
      .adc_out_rd   (adc_out_rd),
      .data_out_adc (data_out_adc),
      .force_flip   (force_flip),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_last       (m_last),
      .seq_num      (seq_num)
   );

   always #5 clk_100m = ~clk_100m;

   int errors = 0, checks = 0;
   logic [31:0] fq[$], part[$], w[$];
   logic [32:0] outq[$], expq[$];
   bit   full_en = 0, ready_lvl = 0, bp_mode = 0, rnd_mode = 0;
   bit   rd_seen = 0, flip_seen = 0, st_prev = 0, in_frame = 0;
   int   rd_total = 0, flips = 0, valid_cnt = 0, nonhdr_out = 0, max_outst = 0;
   int   stall_viol = 0, overread = 0, bp_idx = 0;
   logic [31:0] pd;
   logic        pl;
   logic [15:0] m_seq = 16'd0;
   logic [5:0]  pat = 6'b101001;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: split a bank into frames of at most BL words and list every expected stream word
   function automatic void add_frames(input logic [31:0] ws[$], input bit fl);
      int i = 0;
      int n;
      logic [31:0] sum;
      while (i < ws.size()) begin
         n = (ws.size() - i > BL) ? BL : ws.size() - i;
         sum = 0;
         expq.push_back({1'b0, 16'hA55A, m_seq});
         for (int k = 0; k < n; k++) begin
            expq.push_back({1'b0, ws[i + k]});
            sum += ws[i + k];
         end
`ifdef ADC_PACK_CHECKSUM_EN
         expq.push_back({1'b0, 8'hE0, 7'd0, fl, 16'(n)});
         expq.push_back({1'b1, sum});
`else
         expq.push_back({1'b1, 8'hE0, 7'd0, fl, 16'(n)});
`endif
         m_seq++;
         i += n;
      end
   endfunction

   task automatic cmp_out(input string tag);
      int t = 0;
      while (outq.size() < expq.size() && t < 800) begin
         @(negedge clk_100m);
         t++;
      end
      repeat (8) @(negedge clk_100m);
      chk({tag, "_len"}, 64'(outq.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size() && i < outq.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), 64'(outq[i]), 64'(expq[i]));
      outq.delete();
      expq.delete();
   endtask

   // Output monitor, away from the active edge: handshakes, stall stability, read/flip observation
   always @(negedge clk_100m) begin
      if (rst) begin
         st_prev = 0;
         rd_seen = 0;
         flip_seen = 0;
         in_frame = 0;
      end else begin
         if (st_prev && (!m_valid || m_data !== pd || m_last !== pl)) stall_viol++;
         st_prev = m_valid && !m_ready;
         pd = m_data;
         pl = m_last;
         if (m_valid) valid_cnt++;
         if (m_valid && m_ready) begin
            outq.push_back({m_last, m_data});
            if (in_frame) nonhdr_out++;
            in_frame = !m_last;
         end
         rd_seen = adc_out_rd;
         flip_seen = force_flip;
         if (force_flip) flips++;
         if (rd_total + int'(rd_seen) - nonhdr_out > max_outst) max_outst = rd_total + int'(rd_seen) - nonhdr_out;
      end
   end

   // Ping-pong FIFO read side and sink ready generator
   always @(posedge clk_100m) begin
      #1;
      if (rd_seen) begin
         if (fq.size() == 0) overread++;
         else begin
            data_out_adc = fq.pop_front();
            rd_total++;
         end
      end
      if (flip_seen) while (part.size() != 0) fq.push_back(part.pop_front());
      empty_ppfifo = fq.size() == 0;
      full_ppfifo = full_en && fq.size() != 0;
      if (bp_mode) begin
         m_ready = pat[bp_idx];
         bp_idx = (bp_idx + 1) % 6;
      end else if (rnd_mode) m_ready = $urandom_range(0, 3) != 0;
      else m_ready = ready_lvl;
   end

   initial begin
      int rd0, fl0, v0, t;
      repeat (3) @(negedge clk_100m);
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_seq", 64'(seq_num), 64'd0);
      chk("rst_rd", 64'(adc_out_rd), 64'd0);
      @(posedge clk_100m); #2 rst = 0;
      ready_lvl = 1;
      repeat (3) @(negedge clk_100m);
      // basic frame 1,2,3,4
      rd0 = rd_total;
      w = '{32'd1, 32'd2, 32'd3, 32'd4};
      foreach (w[i]) fq.push_back(w[i]);
      full_en = 1;
      add_frames(w, 0);
      cmp_out("basic");
      chk("basic_reads", 64'(rd_total - rd0), 64'd4);
      chk("basic_seq", 64'(seq_num), 64'd1);
      // backpressure pattern 1,0,0,1,0,1
      stall_viol = 0;
      max_outst = 0;
      bp_mode = 1;
      foreach (w[i]) fq.push_back(w[i]);
      add_frames(w, 0);
      cmp_out("bp");
      bp_mode = 0;
      chk("bp_stall_stable", 64'(stall_viol), 64'd0);
      chk("bp_outstanding_le2", 64'(max_outst <= 2), 64'd1);
      // random bank longer than BURST_LEN, random ready
      rnd_mode = 1;
      w.delete();
      for (int i = 0; i < 7; i++) w.push_back($urandom);
      foreach (w[i]) fq.push_back(w[i]);
      add_frames(w, 0);
      cmp_out("multi");
      chk("multi_seq", 64'(seq_num), 64'(m_seq));
      // flush of a partial bank from IDLE
      full_en = 0;
      w.delete();
      for (int i = 0; i < 3; i++) w.push_back($urandom);
      part = w;
      fl0 = flips;
      done_task = 1;
      add_frames(w, 1);
      cmp_out("flush");
      chk("flush_flips", 64'(flips - fl0), 64'd1);
      // task end during a frame: frame completes unflushed, then a flush frame follows
      done_task = 0;
      repeat (10) @(negedge clk_100m);
      full_en = 1;
      w.delete();
      for (int i = 0; i < 4; i++) w.push_back($urandom);
      foreach (w[i]) fq.push_back(w[i]);
      add_frames(w, 0);
      w.delete();
      for (int i = 0; i < 2; i++) w.push_back($urandom);
      part = w;
      add_frames(w, 1);
      fl0 = flips;
      t = 0;
      while (outq.size() < 2 && t < 200) begin
         @(negedge clk_100m);
         t++;
      end
      done_task = 1;
      cmp_out("mid");
      chk("mid_flips", 64'(flips - fl0), 64'd1);
      rnd_mode = 0;
      // empty flush: one pulse, no frame, timeout back to IDLE
      done_task = 0;
      full_en = 0;
      repeat (10) @(negedge clk_100m);
      fl0 = flips;
      v0 = valid_cnt;
      done_task = 1;
      repeat (80) @(negedge clk_100m);
      chk("eflush_flips", 64'(flips - fl0), 64'd1);
      chk("eflush_no_valid", 64'(valid_cnt - v0), 64'd0);
      chk("eflush_seq", 64'(seq_num), 64'(m_seq));
      rd0 = rd_total;
      fq.push_back(32'h1111);
      fq.push_back(32'h2222);
      repeat (10) @(negedge clk_100m);
      chk("eflush_idle_no_read", 64'(rd_total - rd0), 64'd0);
      fq.delete();
      done_task = 0;
      repeat (10) @(negedge clk_100m);
      // reset while stalled in PAYLOAD
      ready_lvl = 0;
      full_en = 1;
      for (int i = 0; i < 4; i++) fq.push_back($urandom);
      repeat (10) @(negedge clk_100m);
      #2 rst = 1;
      #1;
      chk("rstmid_valid", 64'(m_valid), 64'd0);
      chk("rstmid_data", 64'(m_data), 64'd0);
      chk("rstmid_last", 64'(m_last), 64'd0);
      chk("rstmid_seq", 64'(seq_num), 64'd0);
      chk("rstmid_rd", 64'(adc_out_rd), 64'd0);
      chk("rstmid_flip", 64'(force_flip), 64'd0);
      fq.delete();
      @(posedge clk_100m); #2 rst = 0;
      outq.delete();
      expq.delete();
      m_seq = 0;
      ready_lvl = 1;
      repeat (3) @(negedge clk_100m);
      w.delete();
      for (int i = 0; i < 4; i++) w.push_back($urandom);
      foreach (w[i]) fq.push_back(w[i]);
      add_frames(w, 0);
      cmp_out("after_rst");
      chk("no_overread", 64'(overread), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adc_frame_packer.md
# adc_frame_packer

Host-side drain stage for the ADC ping-pong FIFO, in the `clk_100m` domain. It reads completed banks through `adc_out_rd`/`data_out_adc` and wraps them into framed packets. Each packet carries a header, the payload, a trailer and an optional checksum, and goes out on a valid/ready stream to the host interface. At task end it pulses `force_flip` so a partially filled bank is flushed as a short frame.

## Interface
- `BURST_LEN`, default 512: maximum payload words per frame, range 1..65535.
- `HDR_MAGIC`, default 16'hA55A: header tag.
- `FLIP_WAIT`, default 64: cycles to wait for data after `force_flip` before giving up.

Ports:
- `clk_100m`  in  1  interface clock.
- `rst`  in  1  asynchronous reset, active-high.
- `full_ppfifo`  in  1  a completed bank is readable (level).
- `empty_ppfifo`  in  1  read side empty.
- `done_task`  in  1  task-done level from the `clk_512k` domain; synchronised internally.
- `adc_out_rd`  out  1  FIFO read enable.
- `data_out_adc`  in  32  FIFO read data, valid 1 cycle after `adc_out_rd`.
- `force_flip`  out  1  one-cycle pulse that flips the partial bank.
- `m_data`  out  32  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  final word of frame.
- `seq_num`  out  16  sequence number of the next frame.

## Operation
- **Frame format**
  - Word 0: {`HDR_MAGIC`, seq}.
  - Payload: N words.
  - Trailer: {8'hE0, 7'd0, flush, N[15:0]}.
  - Checksum (macro only): sum of payload words mod 2^32.
- **`done_task` handling:** 2-flop synchroniser, then rising-edge detect. The edge sets `flush_pend`.
- **States:** IDLE, HDR, PAYLOAD, TRAILER, CSUM, FLIP, WAIT.
- **IDLE**
  - `full_ppfifo`=1 goes to HDR with flush=0. This has priority over `flush_pend`.
  - Otherwise `flush_pend`=1 goes to FLIP.
- **FLIP:** `force_flip`=1 for exactly one cycle, clear `flush_pend`, go to WAIT.
- **WAIT**
  - `empty_ppfifo`=0 goes to HDR with flush=1.
  - After `FLIP_WAIT` cycles with the FIFO still empty, go to IDLE. No frame is emitted and seq is unchanged.
- **HDR:** enqueue word 0, then go to PAYLOAD.
- **PAYLOAD**
  - Issue reads while `empty_ppfifo`=0, N < `BURST_LEN`, and there is skid space.
  - Every returned word is enqueued and added to the checksum.
  - Leave for TRAILER when N=`BURST_LEN`, or when `empty_ppfifo`=1 with no read in flight.
- **TRAILER / CSUM:** enqueue the word, set `m_last` on the final word, increment seq (16-bit wrap), return to IDLE.
- **Output buffer:** 2-entry skid buffer.
  - `adc_out_rd` is allowed only when (entries after this cycle's pop + in-flight reads) < 2.
  - No FIFO read is ever issued without guaranteed buffer space.
- **Mid-frame task end:** a `done_task` edge during a frame only sets `flush_pend`. The current frame completes unchanged.
- **Reset:** all outputs 0, seq=0, skid buffer emptied, `flush_pend`=0, state IDLE. Any partial frame is abandoned and no `m_last` is emitted.

## Timing
- `data_out_adc` is sampled on the edge 1 cycle after `adc_out_rd`.
- `m_valid` for the header rises 1 cycle after leaving IDLE.
- Sustained throughput is 1 word/cycle while `m_ready`=1.
- While `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` are held stable.
- `m_valid` never drops without a handshake.
- `force_flip` is a 1-cycle pulse in FLIP. There is at most one pulse per `done_task` edge.
- `done_task` latency to the edge-detect is 2-3 `clk_100m` cycles.
- An N=0 frame is never emitted.

## Configuration
- `ADC_PACK_CHECKSUM_EN`
  - Defined: the CSUM word is appended and carries `m_last`.
  - Undefined: no checksum logic is built; the trailer carries `m_last` and frames are N+2 words.

## Structure
- Package `adc_pack_pkg` holds:
  - the state enum;
  - `TRAILER_TAG`=8'hE0;
  - data width 32 and count width 16.
- Sub-module `pack_skid_buf`: the 2-entry valid/ready skid buffer, exposing an entry count for read gating.
- The synchroniser, FSM and checksum stay in the top module.

## Test plan
- **Basic frame:** `BURST_LEN`=4, `full_ppfifo`=1, FIFO holds 1,2,3,4, `m_ready`=1.
  - Stream is A55A0000, 1, 2, 3, 4, E0000004, 0000000A (`m_last` on the last word).
  - 4 `adc_out_rd` pulses; `seq_num` becomes 1.
- **Backpressure:** same data, `m_ready` pattern 1,0,0,1,0,1...
  - Identical word sequence; no loss or duplication.
  - `m_data` stable while stalled.
  - Skid entries + in-flight never exceed 2.
- **Flush:** `done_task` rises in IDLE, 3 words remain.
  - One `force_flip` pulse.
  - Frame A55A0001, w0..w2, E0010003, sum.
- **Mid-frame task end:** `done_task` rises during PAYLOAD.
  - Current frame finishes with flush=0.
  - Then `force_flip` fires and a flush frame follows.
- **Empty flush:** `done_task` rises with `empty_ppfifo` held 1.
  - One `force_flip` pulse.
  - After 64 cycles back to IDLE; no `m_valid`; `seq_num` unchanged.
- **Reset mid-payload:** `rst` asserted during PAYLOAD.
  - All outputs 0 immediately, `seq_num`=0.
  - Next bank produces a clean frame with seq 0.
